// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Optional divide-by-zero trap: MULDIV_DZ_TRAP_EN.
package muldiv_pkg;

   localparam int XLEN      = 32;
   localparam int DIV_STEPS = 32;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      MUL_WAIT,
      DIV_ITER,
      DIV_FIX
   } state_e;

   function automatic logic [XLEN-1:0] abs_x(input logic [XLEN-1:0] v);
      return v[XLEN-1] ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Command/result bundle between the control unit and the muldiv sequencer.
// dz_err exists only when MULDIV_DZ_TRAP_EN is defined.
interface muldiv_ctrl_if;
   import muldiv_pkg::*;

   logic            start;
   logic            op;
   logic [XLEN-1:0] a_in;
   logic [XLEN-1:0] b_in;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi_out;
   logic [XLEN-1:0] lo_out;
`ifdef MULDIV_DZ_TRAP_EN
   logic            dz_err;

   modport slave (
      input  start, op, a_in, b_in,
      output busy, done, hi_out, lo_out, dz_err
   );
   modport master (
      output start, op, a_in, b_in,
      input  busy, done, hi_out, lo_out, dz_err
   );
`else
   modport slave (
      input  start, op, a_in, b_in,
      output busy, done, hi_out, lo_out
   );
   modport master (
      output start, op, a_in, b_in,
      input  busy, done, hi_out, lo_out
   );
`endif

endinterface

// File: rtl/booth_mul.sv
// Combinational signed radix-4 Booth multiplier, XLEN x XLEN -> 2*XLEN.
module booth_mul
   import muldiv_pkg::*;
(
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   output logic [2*XLEN-1:0] p_o
);

   logic [XLEN:0]     yb;
   logic [2*XLEN-1:0] ax;
   logic [2*XLEN-1:0] pp;
   logic [2*XLEN-1:0] acc;
   logic [2:0]        sel;

   assign yb = {b_i, 1'b0};
   assign ax = {{XLEN{a_i[XLEN-1]}}, a_i};

   always_comb begin
      acc = '0;
      pp  = '0;
      sel = '0;
      for (int i = 0; i < XLEN/2; i++) begin
         sel = yb[2*i +: 3];
         case (sel)
            3'b000, 3'b111: pp = '0;
            3'b001, 3'b010: pp = ax;
            3'b011:         pp = ax << 1;
            3'b100:         pp = -(ax << 1);
            default:        pp = -ax;
         endcase
         acc = acc + (pp << (2*i));
      end
      p_o = acc;
   end

endmodule

// File: rtl/div_step.sv
// One unsigned restoring-division step on a {rem,quo} shift pair.
module div_step
   import muldiv_pkg::*;
(
   input  logic [XLEN:0]   rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN:0]   dvs_i,
   output logic [XLEN:0]   rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0]   sh;
   logic [XLEN+1:0] trial;
   logic            unused_top;

   // rem < divisor <= 2^31, so the top bit never matters after the shift
   assign unused_top = rem_i[XLEN];
   assign sh         = {rem_i[XLEN-1:0], quo_i[XLEN-1]};
   assign trial      = {1'b0, sh} - {1'b0, dvs_i};
   assign rem_o      = trial[XLEN+1] ? sh : trial[XLEN:0];
   assign quo_o      = {quo_i[XLEN-2:0], ~trial[XLEN+1]};

endmodule

// File: rtl/muldiv_ctrl.sv
// MUL/DIV sequencer: fixed-latency Booth multiply, 32-step signed divide.
// MULDIV_DZ_TRAP_EN adds an early-exit divide-by-zero trap with dz_err.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MUL_LAT = 2
) (
   input  logic          clock,
   input  logic          clear,
   muldiv_ctrl_if.slave  bus
);

   state_e            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [XLEN-1:0]   quo_q, quo_d, quo_n;
   logic [XLEN:0]     rem_q, rem_d, rem_n;
   logic [XLEN:0]     dvs_q, dvs_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [XLEN-1:0]   sq, sr;
   logic              qneg_q, qneg_d, rneg_q, rneg_d;
   logic              bz_q, bz_d, done_q, done_d;
   logic [2*XLEN-1:0] prod;
`ifdef MULDIV_DZ_TRAP_EN
   logic              dz_q, dz_d;
`endif

   booth_mul u_mul (
      .a_i (a_q),
      .b_i (b_q),
      .p_o (prod)
   );

   div_step u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (rem_n),
      .quo_o (quo_n)
   );

   assign sq = qneg_q ? -quo_q : quo_q;
   assign sr = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = done_q;
   assign bus.hi_out = hi_q;
   assign bus.lo_out = lo_q;
`ifdef MULDIV_DZ_TRAP_EN
   assign bus.dz_err = dz_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      bz_d    = bz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
`ifdef MULDIV_DZ_TRAP_EN
      dz_d    = dz_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d    = bus.a_in;
               b_d    = bus.b_in;
               cnt_d  = '0;
               rem_d  = '0;
               quo_d  = abs_x(bus.a_in);
               dvs_d  = {1'b0, abs_x(bus.b_in)};
               qneg_d = bus.a_in[XLEN-1] ^ bus.b_in[XLEN-1];
               rneg_d = bus.a_in[XLEN-1];
               bz_d   = (bus.b_in == '0);
               unique case (bus.op)
                  OP_MUL: state_d = MUL_WAIT;
                  OP_DIV: state_d = DIV_ITER;
               endcase
`ifdef MULDIV_DZ_TRAP_EN
               dz_d = 1'b0;
               if (bus.op == OP_DIV && bz_d)
                  state_d = DIV_FIX;
`endif
            end
         end
         MUL_WAIT: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(MUL_LAT - 1)) begin
               hi_d    = prod[2*XLEN-1:XLEN];
               lo_d    = prod[XLEN-1:0];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         DIV_ITER: begin
            rem_d = rem_n;
            quo_d = quo_n;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(DIV_STEPS - 1))
               state_d = DIV_FIX;
         end
         DIV_FIX: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (bz_q) begin
`ifdef MULDIV_DZ_TRAP_EN
               hi_d = '0;
               lo_d = '0;
               dz_d = 1'b1;
`else
               // zero divisor: raw all-ones quotient, dividend passed through
               hi_d = a_q;
               lo_d = quo_q;
`endif
            end else begin
               hi_d = sr;
               lo_d = sq;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         bz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
`ifdef MULDIV_DZ_TRAP_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         bz_q    <= bz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
`ifdef MULDIV_DZ_TRAP_EN
         dz_q    <= dz_d;
`endif
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: MUL_LAT 2 main instance, 1 and 8 for latency.
module tb_muldiv_ctrl;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic        op;
   logic [31:0] a_in;
   logic [31:0] b_in;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   muldiv_ctrl_if b0 ();
   muldiv_ctrl_if b1 ();
   muldiv_ctrl_if b8 ();

   assign b0.start = start;
   assign b0.op    = op;
   assign b0.a_in  = a_in;
   assign b0.b_in  = b_in;
   assign b1.start = start;
   assign b1.op    = op;
   assign b1.a_in  = a_in;
   assign b1.b_in  = b_in;
   assign b8.start = start;
   assign b8.op    = op;
   assign b8.a_in  = a_in;
   assign b8.b_in  = b_in;

   muldiv_ctrl #(.MUL_LAT(2)) u0 (.clock(clock), .clear(clear), .bus(b0));
   muldiv_ctrl #(.MUL_LAT(1)) u1 (.clock(clock), .clear(clear), .bus(b1));
   muldiv_ctrl #(.MUL_LAT(8)) u8 (.clock(clock), .clear(clear), .bus(b8));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      a_in  = a;
      b_in  = b;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output int lat, output int bsy);
      lat = 0;
      bsy = b0.busy ? 1 : 0;
      for (int k = 1; k <= lim; k++) begin
         tick();
         if (b0.done) begin
            lat = k;
            break;
         end
         if (b0.busy) bsy++;
      end
   endtask

   task automatic test_reset();
      clear = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a_in  = '0;
      b_in  = '0;
      tick();
      tick();
      n_cmp++;
      if (b0.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", b0.busy); end
      n_cmp++;
      if (b0.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", b0.done); end
      n_cmp++;
      if (b0.hi_out !== 32'h0) begin n_bad++; $display("FAIL rst_hi: got %h want 0", b0.hi_out); end
      n_cmp++;
      if (b0.lo_out !== 32'h0) begin n_bad++; $display("FAIL rst_lo: got %h want 0", b0.lo_out); end
`ifdef MULDIV_DZ_TRAP_EN
      n_cmp++;
      if (b0.dz_err !== 1'b0) begin n_bad++; $display("FAIL rst_dz: got %b want 0", b0.dz_err); end
`endif
      clear = 1'b0;
      tick();
   endtask

   task automatic test_mul();
      logic [31:0] va [4] = '{32'd7, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd12345};
      logic [31:0] vb [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0};
      logic [63:0] vp [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h1,
                              64'h3FFF_FFFF_0000_0001, 64'h0};
      int lat, bsy;
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, va[i], vb[i]);
         wait_done(20, lat, bsy);
         n_cmp++;
         if (lat !== 2) begin n_bad++; $display("FAIL mul_lat[%0d]: got %0d want 2", i, lat); end
         n_cmp++;
         if ({b0.hi_out, b0.lo_out} !== vp[i]) begin
            n_bad++;
            $display("FAIL mul_prod[%0d]: got %h want %h", i, {b0.hi_out, b0.lo_out}, vp[i]);
         end
         if (i == 0) begin
            n_cmp++;
            if (bsy !== 2) begin n_bad++; $display("FAIL mul_busy_cycles: got %0d want 2", bsy); end
            n_cmp++;
            if (b0.busy !== 1'b0) begin n_bad++; $display("FAIL mul_busy_at_done: got %b want 0", b0.busy); end
         end
         tick();
         n_cmp++;
         if (b0.done !== 1'b0) begin n_bad++; $display("FAIL mul_done_pulse[%0d]: got %b want 0", i, b0.done); end
         n_cmp++;
         if ({b0.hi_out, b0.lo_out} !== vp[i]) begin
            n_bad++;
            $display("FAIL mul_hold[%0d]: got %h want %h", i, {b0.hi_out, b0.lo_out}, vp[i]);
         end
      end
   endtask

   task automatic test_mul_lat();
      int lt [3] = '{0, 0, 0};
      clear = 1'b1;
      tick();
      clear = 1'b0;
      issue(1'b0, 32'h8000_0000, 32'h8000_0000);
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (b0.done && lt[0] == 0) lt[0] = k;
         if (b1.done && lt[1] == 0) lt[1] = k;
         if (b8.done && lt[2] == 0) lt[2] = k;
      end
      n_cmp++;
      if (lt[0] !== 2) begin n_bad++; $display("FAIL lat2: got %0d want 2", lt[0]); end
      n_cmp++;
      if (lt[1] !== 1) begin n_bad++; $display("FAIL lat1: got %0d want 1", lt[1]); end
      n_cmp++;
      if (lt[2] !== 8) begin n_bad++; $display("FAIL lat8: got %0d want 8", lt[2]); end
      n_cmp++;
      if ({b0.hi_out, b0.lo_out} !== 64'h4000_0000_0000_0000) begin
         n_bad++; $display("FAIL minmin_l2: got %h want 4000000000000000", {b0.hi_out, b0.lo_out});
      end
      n_cmp++;
      if ({b1.hi_out, b1.lo_out} !== 64'h4000_0000_0000_0000) begin
         n_bad++; $display("FAIL minmin_l1: got %h want 4000000000000000", {b1.hi_out, b1.lo_out});
      end
      n_cmp++;
      if ({b8.hi_out, b8.lo_out} !== 64'h4000_0000_0000_0000) begin
         n_bad++; $display("FAIL minmin_l8: got %h want 4000000000000000", {b8.hi_out, b8.lo_out});
      end
   endtask

   task automatic test_div();
      logic [31:0] va [5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd7, 32'hFFFF_FF9C};
      logic [31:0] vb [5] = '{32'd2, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF9};
      logic [31:0] vq [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd14, 32'hFFFF_FFFD, 32'd14};
      logic [31:0] vr [5] = '{32'hFFFF_FFFF, 32'd0, 32'd2, 32'd1, 32'hFFFF_FFFE};
      int lat, bsy;
      for (int i = 0; i < 5; i++) begin
         issue(1'b1, va[i], vb[i]);
         wait_done(40, lat, bsy);
         n_cmp++;
         if (lat !== 33) begin n_bad++; $display("FAIL div_lat[%0d]: got %0d want 33", i, lat); end
         n_cmp++;
         if (b0.lo_out !== vq[i]) begin n_bad++; $display("FAIL div_quo[%0d]: got %h want %h", i, b0.lo_out, vq[i]); end
         n_cmp++;
         if (b0.hi_out !== vr[i]) begin n_bad++; $display("FAIL div_rem[%0d]: got %h want %h", i, b0.hi_out, vr[i]); end
         if (i == 0) begin
            n_cmp++;
            if (bsy !== 33) begin n_bad++; $display("FAIL div_busy_cycles: got %0d want 33", bsy); end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int mask = 0;
      int dup  = 0;
      logic prev = 1'b0;
      start = 1'b1;
      op    = 1'b0;
      a_in  = 32'd3;
      b_in  = 32'd4;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 9) start = 1'b0;
         if (b0.done) begin
            mask |= (1 << k);
            if (prev) dup++;
         end
         prev = b0.done;
      end
      n_cmp++;
      if (mask !== 584) begin n_bad++; $display("FAIL b2b_done_cycles: got %0d want 584", mask); end
      n_cmp++;
      if (dup !== 0) begin n_bad++; $display("FAIL b2b_dup_done: got %0d want 0", dup); end
      n_cmp++;
      if (b0.lo_out !== 32'd12) begin n_bad++; $display("FAIL b2b_prod: got %h want c", b0.lo_out); end
      n_cmp++;
      if (b0.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", b0.busy); end
   endtask

   task automatic test_ignored_start();
      int lat, bsy;
      int extra = 0;
      issue(1'b1, 32'd100, 32'd7);
      for (int k = 0; k < 5; k++) tick();
      issue(1'b0, 32'd2, 32'd2);
      wait_done(40, lat, bsy);
      n_cmp++;
      if (lat !== 27) begin n_bad++; $display("FAIL ign_lat: got %0d want 27", lat); end
      n_cmp++;
      if (b0.lo_out !== 32'd14) begin n_bad++; $display("FAIL ign_quo: got %h want e", b0.lo_out); end
      n_cmp++;
      if (b0.hi_out !== 32'd2) begin n_bad++; $display("FAIL ign_rem: got %h want 2", b0.hi_out); end
      for (int k = 0; k < 6; k++) begin
         tick();
         if (b0.done) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin n_bad++; $display("FAIL ign_extra_done: got %0d want 0", extra); end
   endtask

   task automatic test_clear_mid();
      int lat, bsy;
      int late = 0;
      issue(1'b1, 32'd100, 32'd7);
      for (int k = 0; k < 9; k++) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_cmp++;
      if (b0.busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy: got %b want 0", b0.busy); end
      n_cmp++;
      if (b0.done !== 1'b0) begin n_bad++; $display("FAIL clr_done: got %b want 0", b0.done); end
      n_cmp++;
      if ({b0.hi_out, b0.lo_out} !== 64'h0) begin
         n_bad++; $display("FAIL clr_result: got %h want 0", {b0.hi_out, b0.lo_out});
      end
      for (int k = 0; k < 40; k++) begin
         tick();
         if (b0.done) late++;
      end
      n_cmp++;
      if (late !== 0) begin n_bad++; $display("FAIL clr_late_done: got %0d want 0", late); end
      issue(1'b0, 32'd6, 32'd7);
      wait_done(20, lat, bsy);
      n_cmp++;
      if (lat !== 2) begin n_bad++; $display("FAIL clr_mul_lat: got %0d want 2", lat); end
      n_cmp++;
      if ({b0.hi_out, b0.lo_out} !== 64'd42) begin
         n_bad++; $display("FAIL clr_mul_prod: got %h want 2a", {b0.hi_out, b0.lo_out});
      end
      tick();
   endtask

   task automatic test_div_zero();
      int lat, bsy;
      issue(1'b1, 32'd5, 32'd0);
`ifdef MULDIV_DZ_TRAP_EN
      wait_done(40, lat, bsy);
      n_cmp++;
      if (lat !== 1) begin n_bad++; $display("FAIL dz_lat: got %0d want 1", lat); end
      n_cmp++;
      if (b0.dz_err !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b want 1", b0.dz_err); end
      n_cmp++;
      if ({b0.hi_out, b0.lo_out} !== 64'h0) begin
         n_bad++; $display("FAIL dz_result: got %h want 0", {b0.hi_out, b0.lo_out});
      end
      tick();
      n_cmp++;
      if (b0.dz_err !== 1'b1) begin n_bad++; $display("FAIL dz_hold: got %b want 1", b0.dz_err); end
      issue(1'b0, 32'd1, 32'd1);
      n_cmp++;
      if (b0.dz_err !== 1'b0) begin n_bad++; $display("FAIL dz_clear: got %b want 0", b0.dz_err); end
      wait_done(20, lat, bsy);
      n_cmp++;
      if (b0.lo_out !== 32'd1) begin n_bad++; $display("FAIL dz_next_mul: got %h want 1", b0.lo_out); end
`else
      wait_done(40, lat, bsy);
      n_cmp++;
      if (lat !== 33) begin n_bad++; $display("FAIL dz_lat: got %0d want 33", lat); end
      n_cmp++;
      if (b0.lo_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_quo: got %h want ffffffff", b0.lo_out); end
      n_cmp++;
      if (b0.hi_out !== 32'd5) begin n_bad++; $display("FAIL dz_rem: got %h want 5", b0.hi_out); end
      tick();
      issue(1'b1, 32'hFFFF_FFFB, 32'd0);
      wait_done(40, lat, bsy);
      n_cmp++;
      if (b0.hi_out !== 32'hFFFF_FFFB) begin n_bad++; $display("FAIL dz_neg_rem: got %h want fffffffb", b0.hi_out); end
      n_cmp++;
      if (b0.lo_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_neg_quo: got %h want ffffffff", b0.lo_out); end
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mul_lat();
      test_div();
      test_back_to_back();
      test_ignored_start();
      test_clear_mid();
      test_div_zero();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the CPU's multiply/divide resource; sits between the control unit and the HI/LO registers.
- Accepts one MUL or DIV command at a time and latches the operands.
- MUL: drives the combinational radix-4 Booth multiplier for a fixed, parameterised number of cycles, then registers the 64-bit product.
- DIV: runs an internal iterative signed restoring divider.
- Reports busy/done and holds the result on hi_out/lo_out.

Parameters:
- MUL_LAT, 2, cycles from accepted start to done for MUL; legal range 1..8.
- DIV_STEPS, 32, restoring iterations per divide; fixed at the operand width, not to be overridden.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only when busy=0.
- op  in  1  0=signed MUL, 1=signed DIV; sampled with start.
- a_in  in  32  multiplicand / dividend (two's complement).
- b_in  in  32  multiplier / divisor (two's complement).
- busy  out  1  high from the accept edge until the done edge.
- done  out  1  single-cycle completion pulse.
- hi_out  out  32  MUL: product[63:32]; DIV: remainder.
- lo_out  out  32  MUL: product[31:0]; DIV: quotient.
- dz_err  out  1  divide-by-zero flag; present only with MULDIV_DZ_TRAP_EN.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on clear.
- Reset values: busy=0, done=0, hi_out=0, lo_out=0, dz_err=0, state=IDLE, counter=0.
- clear mid-operation: abandons the operation at the next edge with no done pulse; the results are zeroed.
- States: IDLE, MUL_WAIT, DIV_ITER, DIV_FIX.
- Accept: edge T with start=1 and busy=0.
  - Latches op, a_in and b_in; busy=1; counter=0.
  - Next state is MUL_WAIT (op=0) or DIV_ITER (op=1).
- start while busy=1 is ignored; no queueing.
- MUL_WAIT:
  - Counter increments each edge.
  - At edge T+MUL_LAT: {hi_out,lo_out} = signed 64-bit product of the latched operands; done=1; busy=0; return to IDLE.
  - Multiplier inputs are the latched operands, stable for the whole wait.
- DIV_ITER:
  - Edge T also stores |a|, |b| and the quotient/remainder sign bits.
  - Edges T+1..T+32 each perform one restoring step:
    - shift {rem,quo} left by 1;
    - trial = rem − |b|;
    - if trial ≥ 0, rem = trial and quo[0] = 1.
  - Arithmetic is 33-bit unsigned, so |−2^31| = 2^31 is handled.
- DIV_FIX, edge T+33:
  - Apply signs: quotient truncates toward zero; remainder takes the dividend's sign.
  - Drive lo_out/hi_out; done=1; busy=0; go to IDLE.
  - Total DIV latency is 33 cycles.
- Overflow: −2^31 / −1 gives lo_out=32'h8000_0000, hi_out=0. No flag.
- Done cycle: done=1 and busy=0 together. A start in that cycle is accepted at the following edge; done drops to 0 at that edge.
- Hold: hi_out/lo_out hold their value until the next completion or clear.
- Invariant: done is never high for two consecutive cycles.

Optional Feature:
- Macro: MULDIV_DZ_TRAP_EN.
- Defined:
  - DIV with latched b=0 skips DIV_ITER; done is raised at edge T+1.
  - hi_out=0, lo_out=0, dz_err=1.
  - dz_err stays high until the next accepted start or clear.
- Undefined:
  - No dz_err port.
  - Divide by zero runs the full 33 cycles and returns lo_out=32'hFFFF_FFFF, hi_out=a_in (sign fixup suppressed when b=0).

Decomposition:
- Package muldiv_pkg holds:
  - the state enum (IDLE, MUL_WAIT, DIV_ITER, DIV_FIX);
  - op encodings OP_MUL=1'b0, OP_DIV=1'b1;
  - constants XLEN=32, DIV_STEPS=32.
- The existing Booth multiplier is instantiated as-is.
- One natural new sub-module: div_step, the combinational single restoring step (33-bit rem, 32-bit quo, divisor → next rem/quo). The controller keeps the FSM, counter and sign fixup.

Test Plan:
- MUL 7 × −3, MUL_LAT=2: done exactly 2 cycles after the accept edge; {hi,lo}=64'hFFFF_FFFF_FFFF_FFEB; busy high for exactly 2 cycles.
- MUL 32'h8000_0000 × 32'h8000_0000 → {hi,lo}=64'h4000_0000_0000_0000. Repeat for MUL_LAT=1 and MUL_LAT=8; latency must match the parameter.
- DIV −7 / 2 → lo=−3 (32'hFFFF_FFFD), hi=−1, done at 33 cycles. DIV −2^31 / −1 → lo=32'h8000_0000, hi=0.
- Back-to-back: start held high continuously → second command accepted the edge after done; no lost or duplicate done. Start pulses while busy are ignored.
- clear asserted at cycle 10 of a DIV → next cycle busy=0, done=0, outputs 0; no later done pulse. Fresh MUL afterwards is correct.
- DIV 5 / 0:
  - MULDIV_DZ_TRAP_EN defined: done at 1 cycle, dz_err=1, hi=lo=0; dz_err clears on the next start.
  - Undefined: done at 33 cycles, lo=32'hFFFF_FFFF, hi=5.
